player_anim_ctrl: RTL

- Multi-player board-token animation controller, the successor to the single-player ui controller.
- It accepts a move command (player id plus target tile) and animates that token tile by tile: a horizontal glide, then a parabolic hop on every tile.
- A token landing on the final tile triggers a flag-slide sequence and a winner latch.
- It sits between the game-logic block (pos_valid/active_player source) and the sprite renderer (x/y consumer). Time advances only on a frame-rate tick.

---
 rtl/player_anim_pkg.sv | 23 ++
 rtl/player_anim_if.sv | 24 ++
 rtl/player_anim_ctrl_jump_profile.sv | 21 ++
 rtl/player_anim_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/player_anim_pkg.sv
// Shared types and helpers for the board-token animation controller.
package player_anim_pkg;

  localparam int unsigned PIX_W = 10;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVING,
    ST_JUMPING,
    ST_FLAG_SLIDING,
    ST_DONE
  } anim_state_t;

  // Left x of a tile; pitch and origin are elaboration constants at every call site.
  function automatic pix_t tile_x(input int unsigned tile,
                                  input int unsigned origin,
                                  input int unsigned pitch);
    return pix_t'(origin + tile * pitch);
  endfunction

endpackage

// File: rtl/player_anim_if.sv
// Move-command handshake between the game-logic block (master) and the animator (slave).
interface player_anim_if #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned NUM_TILES   = 11
);

  logic                           pos_valid;
  logic [$clog2(NUM_PLAYERS)-1:0] active_player;
  logic [$clog2(NUM_TILES)-1:0]   target_tile;
  logic                           busy;
  logic                           turn_done;
  logic                           err_invalid;

  modport master (
    output pos_valid, active_player, target_tile,
    input  busy, turn_done, err_invalid
  );

  modport slave (
    input  pos_valid, active_player, target_tile,
    output busy, turn_done, err_invalid
  );

endinterface

// File: rtl/player_anim_ctrl_jump_profile.sv
// Parabolic hop height: 4*H*c*(T-c) / T^2, zero at both ends of the hop.
module jump_profile
  import player_anim_pkg::*;
#(
  parameter int unsigned JUMP_TICKS = 16,
  parameter int unsigned JUMP_H     = 16
) (
  input  logic [$clog2(JUMP_TICKS):0] c,
  output pix_t                        offset
);

  localparam int unsigned SHIFT = 2 * $clog2(JUMP_TICKS);

  logic [23:0] prod;

  always_comb begin
    prod   = 24'(4 * JUMP_H) * 24'(c) * (24'(JUMP_TICKS) - 24'(c));
    offset = pix_t'(prod >> SHIFT);
  end

endmodule

// File: rtl/player_anim_ctrl.sv
// Multi-player token animator: tile-by-tile glide plus hop, flag slide and winner latch on the last tile.
module player_anim_ctrl
  import player_anim_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned NUM_TILES   = 11,
  parameter int unsigned TILE_W      = 60,
  parameter int unsigned X_ORIGIN    = 20,
  parameter int unsigned Y_GROUND    = 124,
  parameter int unsigned STEP_PX     = 4,
  parameter int unsigned JUMP_TICKS  = 16,
  parameter int unsigned JUMP_H      = 16,
  parameter int unsigned FLAG_TOP_Y  = 40,
  parameter int unsigned FLAG_BOT_Y  = 124
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick,
  player_anim_if.slave                   cmd,
  output logic [NUM_PLAYERS*PIX_W-1:0]   players_x,
  output logic [NUM_PLAYERS*PIX_W-1:0]   players_y,
  output pix_t                           flag_y,
  output logic                           winner_valid,
  output logic [$clog2(NUM_PLAYERS)-1:0] winner_id
);

  localparam int unsigned PID_W = $clog2(NUM_PLAYERS);
  localparam int unsigned TL_W  = $clog2(NUM_TILES);
  localparam int unsigned CW    = $clog2(JUMP_TICKS) + 1;
  localparam logic [TL_W-1:0] LAST_TILE = TL_W'(NUM_TILES - 1);

  anim_state_t      state, state_n;
  pix_t             px    [NUM_PLAYERS];
  pix_t             py    [NUM_PLAYERS];
  logic [TL_W-1:0]  ptile [NUM_PLAYERS];
  logic [PID_W-1:0] cur_id;
  logic [TL_W-1:0]  cur_tgt;
  pix_t             next_x;
  logic [CW-1:0]    c;
  logic             err_q;

  logic             accept;
  logic [TL_W-1:0]  clamped;
  logic [CW-1:0]    c_inc;
  pix_t             x_inc;
  pix_t             flag_inc;
  pix_t             jump_off;

  jump_profile #(.JUMP_TICKS(JUMP_TICKS), .JUMP_H(JUMP_H)) u_jump (
    .c      (c_inc),
    .offset (jump_off)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    clamped  = (32'(cmd.target_tile) > NUM_TILES - 1) ? LAST_TILE : cmd.target_tile;
    c_inc    = c + 1'b1;
    x_inc    = px[cur_id] + pix_t'(STEP_PX);
    flag_inc = flag_y + 1'b1;
    case (state)
      ST_IDLE:
        if (cmd.pos_valid && !winner_valid && (32'(cmd.active_player) < NUM_PLAYERS)
            && (clamped > ptile[cmd.active_player])) begin
          accept  = 1'b1;
          state_n = ST_MOVING;
        end
      ST_MOVING:
        if (tick && (x_inc == next_x)) state_n = ST_JUMPING;
      ST_JUMPING:
        if (tick && (c_inc == CW'(JUMP_TICKS))) begin
          if (ptile[cur_id] < cur_tgt)  state_n = ST_MOVING;
          else if (cur_tgt == LAST_TILE) state_n = ST_FLAG_SLIDING;
          else                           state_n = ST_DONE;
        end
      ST_FLAG_SLIDING:
        if (tick && (flag_inc == pix_t'(FLAG_BOT_Y))) state_n = ST_DONE;
      ST_DONE:
        state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  assign cmd.busy        = (state != ST_IDLE);
  assign cmd.turn_done   = (state == ST_DONE);
  assign cmd.err_invalid = err_q;

  // Datapath keys off the state/state_n transition so it cannot disagree with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        px[i]    <= pix_t'(X_ORIGIN);
        py[i]    <= pix_t'(Y_GROUND);
        ptile[i] <= '0;
      end
      cur_id       <= '0;
      cur_tgt      <= '0;
      next_x       <= '0;
      c            <= '0;
      err_q        <= 1'b0;
      flag_y       <= pix_t'(FLAG_TOP_Y);
      winner_valid <= 1'b0;
      winner_id    <= '0;
    end else begin
      err_q <= cmd.pos_valid && !accept;
      if (accept) begin
        cur_id  <= cmd.active_player;
        cur_tgt <= clamped;
        next_x  <= tile_x(32'(ptile[cmd.active_player]) + 1, X_ORIGIN, TILE_W);
      end
      if (tick) begin
        case (state)
          ST_MOVING: begin
            px[cur_id] <= x_inc;
            if (state_n == ST_JUMPING) begin
              ptile[cur_id] <= ptile[cur_id] + 1'b1;
              c             <= '0;
            end
          end
          ST_JUMPING: begin
            c          <= c_inc;
            py[cur_id] <= pix_t'(Y_GROUND) - jump_off;
            if (state_n == ST_MOVING)
              next_x <= tile_x(32'(ptile[cur_id]) + 1, X_ORIGIN, TILE_W);
          end
          ST_FLAG_SLIDING: begin
            flag_y <= flag_inc;
            if (state_n == ST_DONE) begin
              winner_valid <= 1'b1;
              winner_id    <= cur_id;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    players_x = '0;
    players_y = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      players_x[i*PIX_W +: PIX_W] = px[i];
      players_y[i*PIX_W +: PIX_W] = py[i];
    end
  end

endmodule
